// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - 8N1 UART with parametrised frame assembly and serialisation
module uart_frame_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BYTES  = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX,
  input  logic                     RXDATA_RETRIEVED,
  output logic                     RXDATA_READY,
  output logic [8*FRAME_BYTES-1:0] RXDATA,
  output logic                     RX_OVERRUN,
  output logic                     RX_FERR,
  output logic                     RX_TIMEOUT,
  input  logic [8*FRAME_BYTES-1:0] TXDATA,
  input  logic                     TXCAPTURE,
  input  logic                     TXTRANSMIT,
  input  logic                     TXACK,
  output logic                     TX,
  output logic                     TXSENT,
  output logic                     TXBUSY
);

  localparam int W   = 8 * FRAME_BYTES;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BCW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TW  = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);

  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0]  IDLE_LAST = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;

  // ---------------- receive path ----------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [W-1:0]    rx_buf_q, rx_buf_d;
  logic [W-1:0]    rxdata_q, rxdata_d;
  logic            ready_q, ready_d;
  logic            overrun_q, overrun_d;
  logic            ferr_q, ferr_d;
  logic            timeout_q, timeout_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle-high reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX bit FSM, frame assembly, hand-off/overrun bookkeeping and partial-frame timeout
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_cnt_d = byte_cnt_q;
    rx_buf_d   = rx_buf_q;
    rxdata_d   = rxdata_q;
    ready_d    = ready_q;
    overrun_d  = overrun_q;
    ferr_d     = 1'b0;
    timeout_d  = 1'b0;
    idle_cnt_d = idle_cnt_q;

    // A retrieve is handled before any frame completing in the same cycle
    if (RXDATA_RETRIEVED) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_buf_d[{byte_cnt_q, 3'b000} +: 8] = rx_shift_q;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              if (ready_d) begin
                overrun_d = 1'b1;
              end else begin
                rxdata_d = rx_buf_d;
                ready_d  = 1'b1;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end else begin
            ferr_d     = 1'b1;
            byte_cnt_d = '0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Idle time only accumulates while a partial frame is pending
    if (rx_state_q != RX_IDLE || byte_cnt_q == '0) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IDLE_LAST) begin
      idle_cnt_d = '0;
      byte_cnt_d = '0;
      timeout_d  = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end
  end

  // RX state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_cnt_q <= '0;
      rx_buf_q   <= '0;
      rxdata_q   <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      timeout_q  <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      byte_cnt_q <= byte_cnt_d;
      rx_buf_q   <= rx_buf_d;
      rxdata_q   <= rxdata_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      timeout_q  <= timeout_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign RXDATA_READY = ready_q;
  assign RXDATA       = rxdata_q;
  assign RX_OVERRUN   = overrun_q;
  assign RX_FERR      = ferr_q;
  assign RX_TIMEOUT   = timeout_q;

  // ---------------- transmit path ----------------
  tx_state_t      tx_state_q, tx_state_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [BCW-1:0] tx_byte_q, tx_byte_d;
  logic [W-1:0]   tx_buf_q, tx_buf_d;
  logic           sent_q, sent_d;
  logic [7:0]     tx_cur_byte;

  assign tx_cur_byte = tx_buf_q[{tx_byte_q, 3'b000} +: 8];

  // TX FSM: back-to-back 8N1 bytes, one DONE cycle, then TXSENT; line driven from state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_buf_d   = tx_buf_q;
    sent_d     = sent_q;
    TX         = 1'b1;

    if (TXACK) sent_d = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        if (TXCAPTURE) tx_buf_d = TXDATA;
        if (TXTRANSMIT) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_byte_d  = '0;
        end
      end
      TX_START: begin
        TX = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        TX = tx_cur_byte[tx_bit_q];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_byte_q == LAST_BYTE) begin
            tx_state_d = TX_DONE;
          end else begin
            tx_byte_d  = tx_byte_q + BCW'(1);
            tx_state_d = TX_START;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DONE: begin
        sent_d     = 1'b1;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_buf_q   <= '0;
      sent_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_buf_q   <= tx_buf_d;
      sent_q     <= sent_d;
    end
  end

  assign TXSENT = sent_q;
  assign TXBUSY = (tx_state_q != TX_IDLE);

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Parametrised successor to the fixed 128-bit UART controller for host-to-FPGA (BBB-FPGA) traffic. It integrates 8N1 serial RX and TX with frame assembly and serialisation of FRAME_BYTES bytes. Over the fixed version it adds configurable frame width and baud divisor, RX framing-error detection, RX overrun detection, inter-byte timeout recovery and a TX busy indication. It sits between the host UART pins and the command decoder / vector-memory logic.

Parameters:
CLKS_PER_BIT, 868, CLK cycles per serial bit (>=4); 868 gives 115200 baud at 100 MHz.
FRAME_BYTES, 16, bytes per frame; data width W = 8*FRAME_BYTES.
TIMEOUT_BITS, 20, idle bit-times after which a partial RX frame is discarded.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
RX  in  1  serial input, asynchronous; idle high
RXDATA_RETRIEVED  in  1  consumer has taken RXDATA
RXDATA_READY  out  1  complete frame valid on RXDATA
RXDATA  out  W  received frame; first byte received in bits [7:0]
RX_OVERRUN  out  1  sticky: a frame was dropped while RXDATA_READY was high
RX_FERR  out  1  one-cycle pulse: stop bit sampled low
RX_TIMEOUT  out  1  one-cycle pulse: partial frame discarded
TXDATA  in  W  frame to send; bits [7:0] are sent first
TXCAPTURE  in  1  load TXDATA into the TX buffer
TXTRANSMIT  in  1  start serialising the buffer
TXACK  in  1  clears TXSENT
TX  out  1  serial output
TXSENT  out  1  whole frame sent; held until TXACK
TXBUSY  out  1  TX state machine not idle

Behaviour:
- Reset (RST low, asynchronous): TX=1; TXSENT, TXBUSY, RXDATA_READY, RX_OVERRUN, RX_FERR, RX_TIMEOUT = 0; RXDATA = 0; TX buffer = 0; byte counters = 0; both FSMs IDLE. Reset mid-frame abandons the frame with no pulses.
- RX input passes a 2-flop synchroniser; all RX timing below is relative to the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge.
  - START samples at CLKS_PER_BIT/2 (integer division). If high, false start -> IDLE. If low, -> DATA.
  - DATA samples 8 bits LSB-first, one every CLKS_PER_BIT cycles.
  - STOP samples once. If high, the byte is accepted into slot byte_cnt. If low, RX_FERR pulses, the byte and the partial frame are discarded, byte_cnt = 0.
- On acceptance of byte FRAME_BYTES-1, the cycle after the stop-bit sample: RXDATA updates, RXDATA_READY = 1, byte_cnt wraps to 0.
- RXDATA_READY and RXDATA hold until RXDATA_RETRIEVED is sampled high. RXDATA_READY clears the next cycle; RX_OVERRUN also clears.
- A frame completing while RXDATA_READY = 1 is dropped: RXDATA is unchanged and RX_OVERRUN = 1. If RETRIEVED and completion fall in the same cycle, the retrieve is processed first and the new frame is stored (READY stays 1, no overrun).
- Timeout: with 0 < byte_cnt < FRAME_BYTES and the RX FSM in IDLE for TIMEOUT_BITS*CLKS_PER_BIT cycles, byte_cnt = 0 and RX_TIMEOUT pulses. The idle counter restarts on every start-bit detection.
- TX FSM states: IDLE, START, DATA, STOP, DONE.
  - TXCAPTURE in IDLE loads TXDATA into the buffer. TXCAPTURE in any other state is ignored.
  - TXTRANSMIT in IDLE starts transmission: TX = 0 from the next cycle and TXBUSY = 1. If TXCAPTURE and TXTRANSMIT are high in the same cycle, the newly captured data is sent.
  - Per byte: start bit 0, 8 data bits LSB-first, stop bit 1, each exactly CLKS_PER_BIT cycles. There is no gap between bytes.
  - After the last stop bit: DONE for one cycle, then TXSENT = 1, TXBUSY = 0, back to IDLE.
  - TXSENT holds until TXACK is sampled high. TXTRANSMIT while TXSENT = 1 is accepted and starts a new frame; TXSENT clears only on TXACK.
- RX and TX are fully independent, full duplex.

Test Plan (CLKS_PER_BIT=4, FRAME_BYTES=4, TIMEOUT_BITS=20 unless stated):
- Send bytes 0x05,0xA1,0x3C,0xFF -> RXDATA=0xFF3CA105, READY high the cycle after the 4th stop-bit sample, held until RETRIEVED, cleared the next cycle.
- Two frames with no RETRIEVED in between -> RXDATA keeps the first frame, RX_OVERRUN=1; RETRIEVED clears both READY and OVERRUN.
- Byte 0x55 with stop bit forced low as the 2nd byte -> one-cycle RX_FERR pulse; a following valid 4 bytes 0x01..0x04 -> RXDATA=0x04030201.
- 2 bytes, then idle for 80 cycles -> RX_TIMEOUT pulse at cycle 80; the next 4 bytes assemble as a fresh frame. Also a 1-cycle RX glitch low -> no byte received.
- TXCAPTURE+TXTRANSMIT with TXDATA=0x00000081 -> TX waveform 0,1,0,0,0,0,0,0,1,1 for byte 0, then 3 bytes 0x00; total 160 cycles; TXSENT high until TXACK; TXCAPTURE with 0xFFFFFFFF mid-frame is ignored.
- Assert RST low mid-RX and mid-TX -> all outputs return immediately to reset values; no RX_FERR or RX_TIMEOUT pulse.
